// File: rtl/chip8_pkg.sv
// rtl/chip8_pkg.sv - shared CHIP-8 constants and sprite_fetch state encoding
// Purpose: screen geometry, sprite bus width and the sprite_fetch FSM state
// codes used by the sprite_fetch top, its bus interface and the bench.
package chip8_pkg;

    localparam int SCREEN_W     = 64;
    localparam int SCREEN_H     = 32;
    localparam int MAX_ROWS     = 15;
    localparam int SPRITE_BUS_W = 8 * MAX_ROWS;

    // sprite_fetch state enum, kept as plain 3-bit codes for legacy tooling
    typedef logic [2:0] sf_state_t;

    localparam sf_state_t SF_IDLE  = 3'd0;
    localparam sf_state_t SF_FETCH = 3'd1;
    localparam sf_state_t SF_WAIT  = 3'd2;
    localparam sf_state_t SF_DRAW1 = 3'd3;
    localparam sf_state_t SF_DRAW2 = 3'd4;
    localparam sf_state_t SF_DONE  = 3'd5;

endpackage

// File: rtl/sprite_fetch_if.sv
// rtl/sprite_fetch_if.sv - memory read bus and GPU draw bus of sprite_fetch
// Purpose: bundles the sprite memory read port and the GPU draw outputs.
// Signals:
//   mem_rd, mem_addr      read strobe and address (driven by master)
//   mem_data              read data, valid the cycle after mem_rd (driven by slave)
//   gpu_draw              draw strobe, high for two cycles per sprite
//   gpu_row, gpu_col      sprite start row / column
//   gpu_height            sprite height in bytes
//   gpu_sprite_data       packed sprite rows, row 0 in the top byte
//   gpu_cycle_count       1 in the first draw cycle, 2 in the second, else 0
interface sprite_fetch_if #(
    parameter int ADDR_W = 12
);
    import chip8_pkg::*;

    logic                    mem_rd;
    logic [ADDR_W-1:0]       mem_addr;
    logic [7:0]              mem_data;
    logic                    gpu_draw;
    logic [7:0]              gpu_row;
    logic [7:0]              gpu_col;
    logic [7:0]              gpu_height;
    logic [SPRITE_BUS_W-1:0] gpu_sprite_data;
    logic [1:0]              gpu_cycle_count;

    modport master (
        output mem_rd, mem_addr,
        input  mem_data,
        output gpu_draw, gpu_row, gpu_col, gpu_height, gpu_sprite_data, gpu_cycle_count
    );

    modport slave (
        input  mem_rd, mem_addr,
        output mem_data,
        input  gpu_draw, gpu_row, gpu_col, gpu_height, gpu_sprite_data, gpu_cycle_count
    );

endinterface

// File: rtl/sprite_fetch.sv
// rtl/sprite_fetch.sv - CHIP-8 DXYN sprite fetch and GPU draw handoff
// Purpose: on start, reads n sprite bytes from memory at I, packs them into a
// 120-bit buffer and presents a two-cycle draw request to the GPU.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           DXYN request, sampled only in IDLE
//   i_addr          sprite base address
//   vx, vy          start column / row register values (reduced mod screen size)
//   n               sprite height in bytes
//   busy            high in FETCH, WAIT, DRAW1, DRAW2
//   done            one-cycle completion pulse
//   bus             memory read + GPU draw bus (master side)
module sprite_fetch #(
    parameter int ADDR_W   = 12,
    parameter int MAX_ROWS = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        vx,
    input  logic [7:0]        vy,
    input  logic [3:0]        n,
    output logic              busy,
    output logic              done,
    sprite_fetch_if.master    bus
);
    import chip8_pkg::*;

    // byte slot of row 0; row k lands MAX_ROWS-1-k slots from the bottom
    localparam logic [3:0] ROW_TOP = 4'(MAX_ROWS - 1);

    sf_state_t               state;
    logic [ADDR_W-1:0]       base;
    logic [7:0]              row;
    logic [7:0]              col;
    logic [3:0]              height;
    logic [3:0]              k;
    logic                    rd_pending;
    logic [3:0]              rd_idx;
    logic [SPRITE_BUS_W-1:0] sprite;
    logic [6:0]              byte_lo;

    // mem_data belongs to the read issued one cycle earlier, so the slot is
    // selected by the index registered alongside that read
    assign byte_lo = 7'(ROW_TOP - rd_idx) << 3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= SF_IDLE;
            base       <= '0;
            row        <= '0;
            col        <= '0;
            height     <= '0;
            k          <= '0;
            rd_pending <= 1'b0;
            rd_idx     <= '0;
            sprite     <= '0;
        end else begin
            rd_pending <= (state == SF_FETCH);
            rd_idx     <= k;

            if (rd_pending) begin
                sprite[byte_lo +: 8] <= bus.mem_data;
            end

            case (state)
                SF_IDLE: begin
                    if (start) begin
                        base   <= i_addr;
                        col    <= vx % 8'(SCREEN_W);
                        row    <= vy % 8'(SCREEN_H);
                        height <= n;
                        k      <= '0;
                        sprite <= '0;
                        state  <= (n == 4'd0) ? SF_DONE : SF_FETCH;
                    end
                end
                SF_FETCH: begin
                    if (k == height - 4'd1) begin
                        state <= SF_WAIT;
                    end else begin
                        k <= k + 4'd1;
                    end
                end
                SF_WAIT:  state <= SF_DRAW1;
                SF_DRAW1: state <= SF_DRAW2;
                SF_DRAW2: state <= SF_DONE;
                SF_DONE:  state <= SF_IDLE;
                default:  state <= SF_IDLE;
            endcase
        end
    end

    assign bus.mem_rd   = (state == SF_FETCH);
    // address wraps naturally at the top of the ADDR_W space
    assign bus.mem_addr = bus.mem_rd ? base + ADDR_W'(k) : '0;

    assign bus.gpu_draw        = (state == SF_DRAW1) || (state == SF_DRAW2);
    assign bus.gpu_cycle_count = (state == SF_DRAW1) ? 2'd1 :
                                 (state == SF_DRAW2) ? 2'd2 : 2'd0;
    assign bus.gpu_row         = row;
    assign bus.gpu_col         = col;
    assign bus.gpu_height      = {4'd0, height};
    assign bus.gpu_sprite_data = sprite;

    assign busy = (state == SF_FETCH) || (state == SF_WAIT) ||
                  (state == SF_DRAW1) || (state == SF_DRAW2);
    assign done = (state == SF_DONE);

endmodule

// File: tb/tb_sprite_fetch.sv
// tb/tb_sprite_fetch.sv - scoreboard bench for sprite_fetch
module tb_sprite_fetch;
    import chip8_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] i_addr = '0;
    logic [7:0]  vx = '0;
    logic [7:0]  vy = '0;
    logic [3:0]  n = '0;
    logic        busy;
    logic        done;

    sprite_fetch_if #(.ADDR_W(12)) bus ();

    sprite_fetch #(.ADDR_W(12), .MAX_ROWS(15)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .i_addr (i_addr),
        .vx     (vx),
        .vy     (vy),
        .n      (n),
        .busy   (busy),
        .done   (done),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    logic [7:0] mem [0:4095];
    always @(posedge clk) if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];

    typedef struct {
        int          cyc;
        logic [11:0] addr;
    } rd_t;

    typedef struct {
        int           cyc;
        logic [1:0]   cc;
        logic [7:0]   row;
        logic [7:0]   col;
        logic [7:0]   height;
        logic [119:0] data;
    } draw_t;

    rd_t   rd_q [$];
    draw_t draw_q [$];
    int    done_q [$];

    int tests = 0;
    int fails = 0;

    int           op_c = 0;
    int           op_n = 0;
    logic         op_active = 1'b0;
    logic [7:0]   exp_row, exp_col, exp_height;
    logic [119:0] exp_data;

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // monitor: pops and compares whenever the DUT presents an output
    rd_t   mr;
    draw_t md;
    int    mdone;
    int    rel;
    logic  exp_busy;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_rd) begin
                if (rd_q.size() == 0) begin
                    check("rd_unexpected", 1, 0);
                end else begin
                    mr = rd_q.pop_front();
                    check("rd_cycle", cyc, mr.cyc);
                    check("rd_addr", bus.mem_addr, mr.addr);
                end
            end
            if (bus.gpu_draw) begin
                if (draw_q.size() == 0) begin
                    check("draw_unexpected", 1, 0);
                end else begin
                    md = draw_q.pop_front();
                    check("draw_cycle", cyc, md.cyc);
                    check("draw_cc", bus.gpu_cycle_count, md.cc);
                    check("draw_row", bus.gpu_row, md.row);
                    check("draw_col", bus.gpu_col, md.col);
                    check("draw_height", bus.gpu_height, md.height);
                    check("draw_data", bus.gpu_sprite_data, md.data);
                end
            end else begin
                check("cc_idle", bus.gpu_cycle_count, 0);
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    mdone = done_q.pop_front();
                    check("done_cycle", cyc, mdone);
                end
            end
            rel      = cyc - op_c;
            exp_busy = op_active && (op_n != 0) && (rel >= 1) && (rel <= op_n + 3);
            check("busy", busy, exp_busy);
        end
    end

    task automatic check_zero(input string name);
        check({name, "_ctl"}, {bus.mem_rd, bus.mem_addr, bus.gpu_draw, bus.gpu_cycle_count,
               bus.gpu_row, bus.gpu_col, bus.gpu_height, busy, done}, 0);
        check({name, "_data"}, bus.gpu_sprite_data, 0);
    endtask

    // called at a negedge: drive the request and push all expected responses
    task automatic push_op(input logic [11:0] a, input logic [7:0] x, input logic [7:0] y,
                           input logic [3:0] nn, input logic [7:0] ecol, input logic [7:0] erow,
                           input logic [119:0] edata);
        int    c;
        rd_t   r;
        draw_t d;
        c = cyc;
        i_addr = a; vx = x; vy = y; n = nn; start = 1'b1;
        for (int k = 0; k < int'(nn); k++) begin
            r.cyc  = c + 1 + k;
            r.addr = a + 12'(k);
            rd_q.push_back(r);
        end
        if (nn != 0) begin
            d.row = erow; d.col = ecol; d.height = {4'd0, nn}; d.data = edata;
            d.cyc = c + int'(nn) + 2; d.cc = 2'd1; draw_q.push_back(d);
            d.cyc = c + int'(nn) + 3; d.cc = 2'd2; draw_q.push_back(d);
            done_q.push_back(c + int'(nn) + 4);
        end else begin
            done_q.push_back(c + 1);
        end
        exp_row = erow; exp_col = ecol; exp_height = {4'd0, nn}; exp_data = edata;
        op_c = c; op_n = int'(nn); op_active = 1'b1;
    endtask

    task automatic wait_done();
        int i;
        i = 0;
        while (done_q.size() != 0 && i < 40) begin
            @(negedge clk);
            i++;
        end
        check("done_timeout", (done_q.size() != 0), 0);
        if (done_q.size() != 0) begin
            rd_q.delete(); draw_q.delete(); done_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic hold_check();
        check("hold_row", bus.gpu_row, exp_row);
        check("hold_col", bus.gpu_col, exp_col);
        check("hold_height", bus.gpu_height, exp_height);
        check("hold_data", bus.gpu_sprite_data, exp_data);
    endtask

    task automatic do_op(input logic [11:0] a, input logic [7:0] x, input logic [7:0] y,
                         input logic [3:0] nn, input logic [7:0] ecol, input logic [7:0] erow,
                         input logic [119:0] edata);
        @(negedge clk);
        push_op(a, x, y, nn, ecol, erow, edata);
        @(negedge clk);
        start = 1'b0;
        wait_done();
        hold_check();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h050] = 8'hF0; mem[12'h051] = 8'h90; mem[12'h052] = 8'h90;
        mem[12'h053] = 8'h90; mem[12'h054] = 8'hF0;
        mem[12'hFFE] = 8'h11; mem[12'hFFF] = 8'h22; mem[12'h000] = 8'h33; mem[12'h001] = 8'h44;
        mem[12'h200] = 8'hA5;
        for (int i = 0; i < 15; i++) mem[12'h300 + 12'(i)] = 8'(i + 1);
        for (int i = 0; i < 8; i++) mem[12'h400 + 12'(i)] = 8'hEE;
        mem[12'h500] = 8'hC3; mem[12'h501] = 8'h3C;

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // font "0"
        do_op(12'h050, 8'd3, 8'd4, 4'd5, 8'd3, 8'd4, {40'hF0909090F0, 80'h0});
        // n = 0: done only, buffer cleared
        do_op(12'h123, 8'd10, 8'd20, 4'd0, 8'd10, 8'd20, 120'h0);
        // address wrap
        do_op(12'hFFE, 8'd0, 8'd0, 4'd4, 8'd0, 8'd0, {32'h11223344, 88'h0});
        // coordinate reduction
        do_op(12'h200, 8'd70, 8'd33, 4'd1, 8'd6, 8'd1, {8'hA5, 112'h0});
        // full height
        do_op(12'h300, 8'd63, 8'd31, 4'd15, 8'd63, 8'd31, 120'h0102030405060708090A0B0C0D0E0F);

        // reset during cycle 3 of an n=8 fetch
        begin
            rd_t r;
            int  c;
            @(negedge clk);
            c = cyc;
            i_addr = 12'h400; vx = 8'd5; vy = 8'd6; n = 4'd8; start = 1'b1;
            for (int k = 0; k < 2; k++) begin
                r.cyc = c + 1 + k; r.addr = 12'h400 + 12'(k); rd_q.push_back(r);
            end
            op_c = c; op_n = 8; op_active = 1'b1;
            @(negedge clk);
            start = 1'b0;
            @(posedge clk);
            @(posedge clk);
            #2;
            rst = 1'b1;
            op_active = 1'b0;
            @(negedge clk);
            check_zero("abort");
            @(posedge clk);
            #2;
            rst = 1'b0;
            repeat (15) @(negedge clk);
            check("abort_reads", rd_q.size(), 0);
        end
        do_op(12'h500, 8'd1, 8'd2, 4'd2, 8'd1, 8'd2, {16'hC33C, 104'h0});

        // start held high through DONE: one operation only
        @(negedge clk);
        push_op(12'h500, 8'd9, 8'd8, 4'd2, 8'd9, 8'd8, {16'hC33C, 104'h0});
        repeat (6) @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (10) @(negedge clk);
        hold_check();

        check("queues_empty", rd_q.size() + draw_q.size() + done_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
